alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one 64-bit ALU between two requesters (0: execute stage, 1: branch/address helper).
//  - Round-robin arbitration between the two requesters.
//  - Latches the winner's operands and drives the external ALU.
//  - Waits for the ALU's clocked ZERO flag, then returns result and flag on a valid/ready response.
//  - Strictly one operation in flight.
// PARAMETERS
//  WIDTH      64  operand/result width
//  OP_W       4   ALU operation code width
//  PRIO_INIT  1   reset value of last_grant; 1 means port 0 wins the first tie
// PORTS
//  clk             in   1      single clock, rising edge
//  reset           in   1      asynchronous, active-high
//  req_valid_0/1   in   1      request valid, per port
//  req_ready_0/1   out  1      request accepted this cycle
//  req_a_0/1       in   WIDTH  operand a
//  req_b_0/1       in   WIDTH  operand b
//  req_op_0/1      in   OP_W   ALU op code (AND 0000, OR 0001, ADD 0010, SLLI 0011,
//                              Beq 0101, Sub 0110, Blt 1000, Bge 1010, NOR 1100, Jal 1110)
//  rsp_valid_0/1   out  1      response valid, per port
//  rsp_ready_0/1   in   1      response consumed
//  rsp_result_0/1  out  WIDTH  captured ALU result
//  rsp_zero_0/1    out  1      captured branch-taken flag
//  alu_a, alu_b    out  WIDTH  operands to the shared ALU
//  alu_op          out  OP_W   op code to the shared ALU
//  alu_result      in   WIDTH  combinational ALU result
//  alu_zero        in   1      ALU flag, registered inside the ALU on posedge clk
// BEHAVIOUR
//  Reset values: every output 0; FSM = IDLE; last_grant = PRIO_INIT.
//  Reset applied mid-operation aborts the op; no response is issued for it.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - req_ready asserts combinationally only on the port chosen by the arbiter.
//   - Arbitration: if only one port is valid, it wins. If both are valid, the port
//     != last_grant wins.
//   - On valid&&ready: latch a, b, op and grant id; go to ISSUE.
//   - The loser's req_ready stays 0; its request must be held.
//  ISSUE:
//   - alu_a/alu_b/alu_op = latched values, held stable through WAIT.
//   - The ALU's ZERO register samples at the end of this cycle.
//  WAIT:
//   - Capture alu_result, and alu_zero masked by op class, into the response regs.
//   - Go to RESP.
//  RESP:
//   - rsp_valid is asserted on the granted port only; payload is stable until accepted.
//   - On rsp_ready: last_grant <= grant id; go to IDLE.
//   - A new request can be accepted in the IDLE cycle that follows.
//  Latency and throughput:
//   - Accept edge to rsp_valid high = 3 cycles.
//   - Best-case throughput = 1 op per 4 cycles.
//  Zero masking:
//   - rsp_zero = alu_zero for Beq/Blt/Bge/Jal.
//   - rsp_zero = 0 for all other ops, because the ALU flag holds stale state on non-branch ops.
//  Undefined op codes are forwarded unchanged: result is whatever the ALU returns (0 by
//   default), and rsp_zero = 0.
//  alu_* outputs keep their last latched values while in IDLE; they are not cleared.
//  Comparisons and arithmetic are entirely inside the ALU; this block performs no width
//   conversion.
// STRUCTURE
//  Shared package alu_ops_pkg:
//   - op code localparams
//   - is_branch_op(op) function
//   - FSM state encoding (2-bit: IDLE 00, ISSUE 01, WAIT 10, RESP 11)
//  Sub-module rr_arb2:
//   - inputs: 2 valids, last_grant
//   - outputs: one-hot grant
//   - purely combinational
//  The ALU is instantiated outside this block, next to it in the execute stage.
// TESTING
//  1. Single op, no contention: port0 ADD a=5, b=7 -> req_ready_0 high at the accept
//     edge; rsp_valid_0 high 3 cycles later with result=12, zero=0.
//  2. Tie after reset: both ports valid (p0 Sub 9-4, p1 OR 0xF0|0x0F).
//     -> p0 served first with result=5.
//     -> then p1 with result=0xFF.
//     -> rsp_valid_1 is never asserted while p0 is in flight.
//  3. Fairness: both ports always valid for 8 ops -> grants strictly alternate
//     0,1,0,1,... and each port gets 4 ops.
//  4. Branch flag and masking:
//     -> p1 Beq a=b=3 gives zero=1.
//     -> Bge a=2, b=9 gives zero=0.
//     -> ADD issued immediately after the taken Beq gives zero=0.
//  5. Response backpressure: hold rsp_ready_0=0 for 5 cycles -> payload stable,
//     no new request accepted; release -> IDLE next cycle.
//  6. Reset asserted in WAIT: all outputs go to 0 asynchronously; after release,
//     no stale rsp_valid, and the next tie goes to port 0.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// Shared definitions for the shared-ALU controller: op codes, branch-op
// classification, FSM state encoding and the latched request payload.
package alu_ops_pkg;

    localparam int unsigned ALU_WIDTH = 64;
    localparam int unsigned ALU_OP_W  = 4;

    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_SLLI = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_BEQ  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_BLT  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_BGE  = 4'b1010;
    localparam logic [ALU_OP_W-1:0] OP_NOR  = 4'b1100;
    localparam logic [ALU_OP_W-1:0] OP_JAL  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [ALU_OP_W-1:0]  op;
    } alu_req_t;

    // Ops whose ALU flag is meaningful; all others leave it stale.
    function automatic logic is_branch_op(input logic [ALU_OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGE) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bundle of the two requester ports and the shared-ALU port.
//   slave  : view of the controller (accepts requests, masters the ALU)
//   master : view of the surrounding execute stage (requesters + ALU)
interface alu_share_ctrl_if;
    import alu_ops_pkg::*;

    logic                 req_valid_0, req_valid_1;
    logic                 req_ready_0, req_ready_1;
    logic [ALU_WIDTH-1:0] req_a_0, req_a_1;
    logic [ALU_WIDTH-1:0] req_b_0, req_b_1;
    logic [ALU_OP_W-1:0]  req_op_0, req_op_1;
    logic                 rsp_valid_0, rsp_valid_1;
    logic                 rsp_ready_0, rsp_ready_1;
    logic [ALU_WIDTH-1:0] rsp_result_0, rsp_result_1;
    logic                 rsp_zero_0, rsp_zero_1;
    logic [ALU_WIDTH-1:0] alu_a, alu_b;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [ALU_WIDTH-1:0] alu_result;
    logic                 alu_zero;

    modport slave (
        input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
               req_op_0, req_op_1, rsp_ready_0, rsp_ready_1, alu_result, alu_zero,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_result_0, rsp_result_1, rsp_zero_0, rsp_zero_1, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
               req_op_0, req_op_1, rsp_ready_0, rsp_ready_1, alu_result, alu_zero,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_result_0, rsp_result_1, rsp_zero_0, rsp_zero_1, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   i_valid      : request valids, bit per port
//   i_last_grant : port granted most recently
//   o_grant_c    : one-hot grant (zero when nothing is valid)
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant_c
);

    always_comb begin
        o_grant_c = 2'b00;
        case (i_valid)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            // Tie: the port that did not win last time goes first.
            2'b11:   o_grant_c = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters, one op in flight.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : requester ports 0/1 (valid/ready request, valid/ready response)
//                and the shared-ALU operands/op out, result/flag in
module alu_share_ctrl
    import alu_ops_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_WIDTH,
    parameter int unsigned OP_W      = ALU_OP_W,
    parameter int unsigned PRIO_INIT = 1
) (
    input  logic            clk,
    input  logic            reset,
    alu_share_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;
    logic             r_grant_id;
    alu_req_t         r_req;
    alu_req_t         w_win_req;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic [1:0]       r_rsp_valid;
    logic [1:0]       w_grant;
    logic             w_req_ready_0;
    logic             w_req_ready_1;
    logic             w_accept;
    logic             w_rsp_ready;
    logic             w_rsp_fire;
    logic [OP_W-1:0]  w_op;

    rr_arb2 u_arb (
        .i_valid      ({bus.req_valid_1, bus.req_valid_0}),
        .i_last_grant (r_last_grant),
        .o_grant_c    (w_grant)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  w_next_state = ST_RESP;
            ST_RESP:  if (w_rsp_fire) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output / handshake decode; ready is held low during reset so every output is 0
    always_comb begin
        w_req_ready_0 = 1'b0;
        w_req_ready_1 = 1'b0;
        if ((r_state == ST_IDLE) && !reset) begin
            w_req_ready_0 = w_grant[0];
            w_req_ready_1 = w_grant[1];
        end
        w_accept    = w_req_ready_0 | w_req_ready_1;
        w_rsp_ready = r_grant_id ? bus.rsp_ready_1 : bus.rsp_ready_0;
        w_rsp_fire  = (r_state == ST_RESP) && w_rsp_ready;
        w_win_req   = w_grant[1] ? '{a: bus.req_a_1, b: bus.req_b_1, op: bus.req_op_1}
                                 : '{a: bus.req_a_0, b: bus.req_b_0, op: bus.req_op_0};
        w_op        = r_req.op;
    end

    // Request latch, response capture and round-robin history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req        <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'(PRIO_INIT);
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_valid  <= 2'b00;
        end else begin
            if (w_accept) begin
                r_req      <= w_win_req;
                r_grant_id <= w_grant[1];
            end
            // ALU flag register has sampled the ISSUE operands by now.
            if (r_state == ST_WAIT) begin
                r_rsp_result <= bus.alu_result;
                r_rsp_zero   <= is_branch_op(w_op) & bus.alu_zero;
                r_rsp_valid  <= r_grant_id ? 2'b10 : 2'b01;
            end
            if (w_rsp_fire) begin
                r_rsp_valid  <= 2'b00;
                r_last_grant <= r_grant_id;
            end
        end
    end

    assign bus.req_ready_0  = w_req_ready_0;
    assign bus.req_ready_1  = w_req_ready_1;
    assign bus.rsp_valid_0  = r_rsp_valid[0];
    assign bus.rsp_valid_1  = r_rsp_valid[1];
    assign bus.rsp_result_0 = r_rsp_result;
    assign bus.rsp_result_1 = r_rsp_result;
    assign bus.rsp_zero_0   = r_rsp_zero;
    assign bus.rsp_zero_1   = r_rsp_zero;
    assign bus.alu_a        = r_req.a;
    assign bus.alu_b        = r_req.b;
    assign bus.alu_op       = r_req.op;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU next to the DUT, per-port
// requester queues, and a transaction-level model of arbitration/latency.
module tb_alu_share_ctrl;
    import alu_ops_pkg::*;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
    } rq_t;

    typedef struct {
        bit          port;
        logic [63:0] res;
        logic        z;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic r_flag = 1'b0;

    always #5 clk = ~clk;

    alu_share_ctrl_if bus ();

    alu_share_ctrl #(.WIDTH(64), .OP_W(4), .PRIO_INIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    rq_t  q0[$];
    rq_t  q1[$];
    obs_t obs[$];
    int   grants[$];

    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_hs_cyc = 0;
    bit          busy = 0;
    bit          hs_pend = 0;
    bit          hs_port = 0;
    bit          exp_port = 0;
    bit          last_grant = 1;
    logic [63:0] exp_res = '0;
    logic        exp_zero = 1'b0;
    int          hold_cnt = 0;
    bit          rnd_rsp = 0;
    bit          rnd_gen = 0;

    // External ALU behaviour
    function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a << b[5:0];
            4'b0101: return a - b;
            4'b0110: return a - b;
            4'b1000: return 64'($signed(a) < $signed(b));
            4'b1010: return 64'($signed(a) >= $signed(b));
            4'b1100: return ~(a | b);
            4'b1110: return a + 64'd4;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit is_br(input logic [3:0] op);
        return (op == 4'b0101) || (op == 4'b1000) || (op == 4'b1010) || (op == 4'b1110);
    endfunction

    // Branch-taken outcome; non-branch ops report 0 to the requester
    function automatic logic taken(input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] op);
        case (op)
            4'b0101: return a == b;
            4'b1000: return $signed(a) < $signed(b);
            4'b1010: return $signed(a) >= $signed(b);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_zero   = r_flag;

    // Flag updates only on branch ops, otherwise keeps its stale value
    always @(posedge clk) begin
        if (is_br(bus.alu_op)) r_flag <= taken(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic rq_t mk(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        rq_t r;
        r.a = a; r.b = b; r.op = op;
        return r;
    endfunction

    function automatic rq_t rand_req();
        rq_t r;
        r.op = 4'($urandom_range(0, 15));
        r.a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
        r.b  = ($urandom_range(0, 3) == 0) ? r.a : {$urandom, $urandom};
        return r;
    endfunction

    task automatic drive_reqs();
        if (rnd_gen && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
        if (rnd_gen && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
        bus.req_valid_0 = (q0.size() != 0);
        bus.req_valid_1 = (q1.size() != 0);
        if (q0.size() != 0) begin
            bus.req_a_0 = q0[0].a; bus.req_b_0 = q0[0].b; bus.req_op_0 = q0[0].op;
        end else begin
            bus.req_a_0 = {$urandom, $urandom}; bus.req_b_0 = {$urandom, $urandom};
            bus.req_op_0 = 4'($urandom);
        end
        if (q1.size() != 0) begin
            bus.req_a_1 = q1[0].a; bus.req_b_1 = q1[0].b; bus.req_op_1 = q1[0].op;
        end else begin
            bus.req_a_1 = {$urandom, $urandom}; bus.req_b_1 = {$urandom, $urandom};
            bus.req_op_1 = 4'($urandom);
        end
    endtask

    // One clock of model + checks
    task automatic step();
        bit   ev0, ev1, er0, er1, rr, v0, v1;
        rq_t  r;
        @(posedge clk);
        #1;
        cyc++;
        if (hs_pend) begin
            busy       = 0;
            last_grant = hs_port;
            hs_pend    = 0;
        end
        // Response appears three cycles after the accepting IDLE cycle
        ev0 = busy && (cyc - acc_cyc >= 3) && (exp_port == 1'b0);
        ev1 = busy && (cyc - acc_cyc >= 3) && (exp_port == 1'b1);
        chk("rsp_valid_0", 64'(bus.rsp_valid_0), 64'(ev0));
        chk("rsp_valid_1", 64'(bus.rsp_valid_1), 64'(ev1));
        if (ev0) begin
            chk("rsp_result_0", bus.rsp_result_0, exp_res);
            chk("rsp_zero_0", 64'(bus.rsp_zero_0), 64'(exp_zero));
        end
        if (ev1) begin
            chk("rsp_result_1", bus.rsp_result_1, exp_res);
            chk("rsp_zero_1", 64'(bus.rsp_zero_1), 64'(exp_zero));
        end
        rr = rnd_rsp ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (hold_cnt > 0 && (ev0 || ev1)) begin
            rr = 1'b0;
            hold_cnt--;
        end
        bus.rsp_ready_0 = ev0 ? rr : 1'($urandom);
        bus.rsp_ready_1 = ev1 ? rr : 1'($urandom);
        if ((ev0 || ev1) && rr) begin
            hs_pend = 1;
            hs_port = exp_port;
            last_hs_cyc = cyc;
            obs.push_back('{exp_port, ev1 ? bus.rsp_result_1 : bus.rsp_result_0,
                            ev1 ? bus.rsp_zero_1 : bus.rsp_zero_0});
        end
        drive_reqs();
        #1;
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        er0 = 0;
        er1 = 0;
        if (!busy) begin
            if (v0 && !v1) er0 = 1;
            else if (v1 && !v0) er1 = 1;
            else if (v0 && v1) begin
                if (last_grant) er0 = 1;
                else er1 = 1;
            end
        end
        chk("req_ready_0", 64'(bus.req_ready_0), 64'(er0));
        chk("req_ready_1", 64'(bus.req_ready_1), 64'(er1));
        if (er0 || er1) begin
            r = er1 ? q1.pop_front() : q0.pop_front();
            exp_res  = alu_ref(r.a, r.b, r.op);
            exp_zero = taken(r.a, r.b, r.op);
            exp_port = er1;
            acc_cyc  = cyc;
            busy     = 1;
            grants.push_back(int'(er1));
        end
    endtask

    task automatic drain(input int max_cyc, input string tag);
        int n = 0;
        bit stuck;
        while ((q0.size() != 0 || q1.size() != 0 || busy || hs_pend) && n < max_cyc) begin
            step();
            n++;
        end
        stuck = (q0.size() != 0 || q1.size() != 0 || busy || hs_pend);
        if (stuck) chk(tag, 64'(stuck), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready_0"},  64'(bus.req_ready_0), 64'd0);
        chk({tag, "_req_ready_1"},  64'(bus.req_ready_1), 64'd0);
        chk({tag, "_rsp_valid_0"},  64'(bus.rsp_valid_0), 64'd0);
        chk({tag, "_rsp_valid_1"},  64'(bus.rsp_valid_1), 64'd0);
        chk({tag, "_rsp_result_0"}, bus.rsp_result_0, 64'd0);
        chk({tag, "_rsp_result_1"}, bus.rsp_result_1, 64'd0);
        chk({tag, "_rsp_zero"},     64'({bus.rsp_zero_1, bus.rsp_zero_0}), 64'd0);
        chk({tag, "_alu_a"},        bus.alu_a, 64'd0);
        chk({tag, "_alu_b"},        bus.alu_b, 64'd0);
        chk({tag, "_alu_op"},       64'(bus.alu_op), 64'd0);
    endtask

    initial begin
        int mark;
        int cnt0;
        reset = 1'b1;
        bus.rsp_ready_0 = 0; bus.rsp_ready_1 = 0;
        drive_reqs();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single uncontended ADD
        obs.delete();
        q0.push_back(mk(64'd5, 64'd7, OP_ADD));
        drain(40, "t1_drain");
        chk("t1_count", 64'(obs.size()), 64'd1);
        if (obs.size() >= 1) begin
            chk("t1_result", obs[0].res, 64'd12);
            chk("t1_zero", 64'(obs[0].z), 64'd0);
        end

        // Tie: port 0 first (last grant 0 now, so p1 would win; re-reset first)
        reset = 1'b1;
        #1;
        reset = 1'b0;
        last_grant = 1;
        obs.delete();
        mark = grants.size();
        q0.push_back(mk(64'd9, 64'd4, OP_SUB));
        q1.push_back(mk(64'hF0, 64'h0F, OP_OR));
        drain(40, "t2_drain");
        chk("t2_count", 64'(obs.size()), 64'd2);
        if (obs.size() >= 2) begin
            chk("t2_first_port", 64'(obs[0].port), 64'd0);
            chk("t2_first_res", obs[0].res, 64'd5);
            chk("t2_second_port", 64'(obs[1].port), 64'd1);
            chk("t2_second_res", obs[1].res, 64'hFF);
        end

        // Fairness under constant contention
        mark = grants.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        drain(80, "t3_drain");
        chk("t3_ops", 64'(grants.size() - mark), 64'd8);
        if (grants.size() - mark == 8) begin
            cnt0 = 0;
            chk("t3_first", 64'(grants[mark]), 64'd0);
            for (int i = 0; i < 8; i++) begin
                if (grants[mark + i] == 0) cnt0++;
                if (i > 0) chk("t3_alternate", 64'(grants[mark + i]), 64'(1 - grants[mark + i - 1]));
            end
            chk("t3_port0_ops", 64'(cnt0), 64'd4);
        end

        // Branch flag and masking of the stale flag
        obs.delete();
        q1.push_back(mk(64'd3, 64'd3, OP_BEQ));
        q1.push_back(mk(64'd1, 64'd1, OP_ADD));
        drain(40, "t4a_drain");
        q0.push_back(mk(64'd2, 64'd9, OP_BGE));
        drain(40, "t4b_drain");
        chk("t4_count", 64'(obs.size()), 64'd3);
        if (obs.size() >= 3) begin
            chk("t4_beq_zero", 64'(obs[0].z), 64'd1);
            chk("t4_add_zero", 64'(obs[1].z), 64'd0);
            chk("t4_add_res", obs[1].res, 64'd2);
            chk("t4_bge_zero", 64'(obs[2].z), 64'd0);
        end

        // Response backpressure with a competing request arriving meanwhile
        obs.delete();
        mark = grants.size();
        hold_cnt = 5;
        q0.push_back(mk(64'd1, 64'd2, OP_ADD));
        step();
        step();
        q1.push_back(mk(64'd6, 64'd3, OP_SUB));
        for (int i = 0; i < 40 && obs.size() == 0; i++) step();
        step();
        chk("t5_next_accept", 64'(acc_cyc), 64'(last_hs_cyc + 1));
        chk("t5_next_port", 64'(exp_port), 64'd1);
        drain(40, "t5_drain");
        chk("t5_hold_used", 64'(hold_cnt), 64'd0);

        // Random traffic with random response backpressure
        rnd_gen = 1;
        rnd_rsp = 1;
        for (int i = 0; i < 2000; i++) step();
        rnd_gen = 0;
        rnd_rsp = 0;
        drain(60, "rand_drain");

        // Reset while the op sits in WAIT
        q0.push_back(mk(64'd100, 64'd23, OP_ADD));
        for (int i = 0; i < 20 && !(busy && cyc == acc_cyc + 2); i++) step();
        chk("t6_reach_wait", 64'(busy && cyc == acc_cyc + 2), 64'd1);
        bus.req_valid_1 = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6");
        q0.delete();
        q1.delete();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        busy = 0;
        hs_pend = 0;
        hold_cnt = 0;
        last_grant = 1;
        obs.delete();
        mark = grants.size();
        q0.push_back(rand_req());
        q1.push_back(rand_req());
        drain(40, "t6_drain");
        chk("t6_ops", 64'(grants.size() - mark), 64'd2);
        if (grants.size() - mark >= 1) chk("t6_tie_port0", 64'(grants[mark]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
